// File: rtl/sdm_ndiv_pkg.sv
// ---------------------------------------------------------------------------
// sdm_ndiv_pkg
// Shared widths, types and the clamp helper for the fractional-N divider
// control block.
//   FRAC_W  width of the (3,5) fixed-point target
//   INT_W   width of the integer divide value n
//   FBITS   fraction width, also the accumulator width
//   NX_W    signed width used to combine integer part and carries
// ---------------------------------------------------------------------------
package sdm_ndiv_pkg;

  localparam int FRAC_W = 8;
  localparam int INT_W  = 3;
  localparam int FBITS  = 5;
  localparam int NX_W   = 5;

  // Legal range of the divide value; the combined modulator output can reach
  // -1..9 with MASH 1-1 and is clamped into this window.
  localparam logic signed [NX_W-1:0] N_MIN = NX_W'(0);
  localparam logic signed [NX_W-1:0] N_MAX = NX_W'(7);

  typedef logic [FRAC_W-1:0] frac_t;
  typedef logic [INT_W-1:0]  ndiv_t;

  // Fixed-point target split into integer and fractional parts.
  typedef struct packed {
    logic [INT_W-1:0] int_part;
    logic [FBITS-1:0] frac_part;
  } target_t;

  function automatic ndiv_t clamp_n(input logic signed [NX_W-1:0] nx);
    ndiv_t r;
    if (nx < N_MIN)      r = ndiv_t'(N_MIN);
    else if (nx > N_MAX) r = ndiv_t'(N_MAX);
    else                 r = ndiv_t'(nx);
    return r;
  endfunction

endpackage

// File: rtl/sdm_ndiv_if.sv
// ---------------------------------------------------------------------------
// sdm_ndiv_if
// Load port and divider outputs of sdm_ndiv.
//   frac_in    target value, (3,5) fixed point
//   frac_vld   frac_in valid
//   frac_rdy   holding register empty; transfer on frac_vld & frac_rdy
//   n          integer divide value for the current period
//   div_pulse  one-cycle strobe on the last clk of each divide period
// master: the side that supplies targets; slave: the divider.
// ---------------------------------------------------------------------------
interface sdm_ndiv_if;
  import sdm_ndiv_pkg::*;

  frac_t frac_in;
  logic  frac_vld;
  logic  frac_rdy;
  ndiv_t n;
  logic  div_pulse;

  modport master (
    output frac_in, frac_vld,
    input  frac_rdy, n, div_pulse
  );

  modport slave (
    input  frac_in, frac_vld,
    output frac_rdy, n, div_pulse
  );

endinterface

// File: rtl/sdm_acc.sv
// ---------------------------------------------------------------------------
// sdm_acc
// FBITS-bit modulo accumulator with carry out. The accumulator only updates
// when en_i is high; the carry is forced low while disabled so a stalled
// stage never contributes to the divide value.
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        advance the accumulator this cycle
//   addend_i    value added to the accumulator
//   sum_o       wrapped sum (the value the accumulator takes if enabled)
//   carry_o     overflow of acc + addend, qualified by en_i
// ---------------------------------------------------------------------------
module sdm_acc
  import sdm_ndiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [FBITS-1:0] addend_i,
  output logic [FBITS-1:0] sum_o,
  output logic             carry_o
);

  logic [FBITS-1:0] acc_q;
  logic [FBITS-1:0] acc_d;
  logic [FBITS:0]   sum_w;

  assign sum_w   = {1'b0, acc_q} + {1'b0, addend_i};
  assign sum_o   = sum_w[FBITS-1:0];
  assign carry_o = en_i & sum_w[FBITS];
  assign acc_d   = en_i ? sum_o : acc_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/sdm_ndiv.sv
// ---------------------------------------------------------------------------
// sdm_ndiv
// Fractional-N divider control. Turns a (3,5) fixed-point target into a
// per-period integer divide value n whose long-run mean equals the target,
// and contains the feedback divide counter that consumes n.
//   ORDER   1 = single accumulator, 2 = MASH 1-1
//   INIT_N  divide value used after reset
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sdm_ndiv_if.slave: frac_in/frac_vld/frac_rdy load port,
//               n and div_pulse outputs
// A new target goes into a one-deep holding register and becomes active on
// the next period boundary. The modulator runs once per boundary on the
// active target; its result is the n of the following period.
// ---------------------------------------------------------------------------
module sdm_ndiv
  import sdm_ndiv_pkg::*;
#(
  parameter int ORDER  = 1,
  parameter int INIT_N = 3
) (
  input logic       clk,
  input logic       rst_n,
  sdm_ndiv_if.slave bus
);

  localparam ndiv_t   INIT_NDIV   = ndiv_t'(INIT_N);
  localparam target_t INIT_TARGET = target_t'({INIT_NDIV, FBITS'(0)});

  ndiv_t   cnt_q,      cnt_d;
  ndiv_t   n_q,        n_d;
  target_t active_q,   active_d;
  target_t hold_q,     hold_d;
  logic    hold_vld_q, hold_vld_d;
  logic    c2_prev_q,  c2_prev_d;

  logic             tick;
  logic             frac_rdy_w;
  logic             acc_en;
  logic [FBITS-1:0] s1_sum;
  logic             c1;
  logic             c2;
  logic signed [NX_W-1:0] nx;

  // Last cycle of the divide period: counter has run down to zero.
  assign tick       = (cnt_q == '0);
  assign frac_rdy_w = ~hold_vld_q;

  // With a zero fraction the accumulators must hold, otherwise the MASH
  // second stage would keep integrating the frozen first-stage value.
  assign acc_en = tick & (|active_q.frac_part);

  sdm_acc u_acc1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (acc_en),
    .addend_i (active_q.frac_part),
    .sum_o    (s1_sum),
    .carry_o  (c1)
  );

  if (ORDER == 2) begin : g_mash
    logic [FBITS-1:0] s2_sum_unused;
    logic             c2_w;

    // Second stage integrates the first stage's residue.
    sdm_acc u_acc2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (acc_en),
      .addend_i (s1_sum),
      .sum_o    (s2_sum_unused),
      .carry_o  (c2_w)
    );
    assign c2 = c2_w;
  end else begin : g_first
    logic s1_sum_unused;
    assign s1_sum_unused = ^s1_sum;
    assign c2            = 1'b0;
  end

  // int + c1 + c2 - c2_prev: the differentiated second-stage carry can make
  // the sum go negative, hence the signed combine before clamping.
  assign nx = $signed(NX_W'(active_q.int_part)) + $signed(NX_W'(c1))
            + $signed(NX_W'(c2)) - $signed(NX_W'(c2_prev_q));

  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is
    // inferred on paths that do not assign it.
    cnt_d      = cnt_q - ndiv_t'(1);
    n_d        = n_q;
    active_d   = active_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    c2_prev_d  = c2_prev_q;

    if (tick) begin
      n_d       = clamp_n(nx);
      cnt_d     = n_d;
      c2_prev_d = c2;
      // The modulator above used the old target; the held one takes over
      // from the next boundary on.
      if (hold_vld_q) begin
        active_d   = hold_q;
        hold_vld_d = 1'b0;
      end
    end

    // Accepted only while empty, so it never collides with the release above.
    if (bus.frac_vld && frac_rdy_w) begin
      hold_d     = target_t'(bus.frac_in);
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= INIT_NDIV;
      n_q        <= INIT_NDIV;
      active_q   <= INIT_TARGET;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      c2_prev_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      active_q   <= active_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      c2_prev_q  <= c2_prev_d;
    end
  end

  assign bus.frac_rdy  = frac_rdy_w;
  assign bus.n         = n_q;
  assign bus.div_pulse = tick;

endmodule
